pp_mac_pipe_multi: RTL and testbench

- Parametrised successor to the fixed 12ns x 9s, 4-stage DSP multiplier used in the pp_pipeline_accel datapath.
- Applies one coefficient per lane across LANES parallel lanes.
- Two per-beat modes: plain multiply, or multiply-accumulate over a first/last-delimited run.
- Each lane performs rounding right-shift and saturation, and reports a saturation flag.
- Valid/ready stream stage between pixel unpack and colour-convert/filter outputs; maps to DSP48 slices.

---
 rtl/pp_mac_pipe_multi_pkg.sv | 54 +++++
 rtl/pp_mac_pipe_multi_if.sv | 29 ++
 rtl/pp_mac_pipe_multi_lane.sv | 88 ++++++++
 rtl/pp_mac_pipe_multi.sv | 72 +++++++
 tb/tb_pp_mac_pipe_multi.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_mac_pipe_multi_pkg.sv
// Shared types, width helpers and the round/saturate function for the
// multi-lane multiply/MAC pipeline.
package pp_mac_pkg;

    typedef enum logic {
        MODE_MULT = 1'b0,
        MODE_MAC  = 1'b1
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  first;
        logic  last;
    } ctrl_t;

    // Round/saturate is evaluated at this fixed width; ACC_W must stay below it.
    localparam int RS_W = 64;

    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic int acc_w(input int a_w, input int b_w, input int guard);
        return a_w + b_w + guard;
    endfunction

    // Returns {clamped value, saturated flag}.
    function automatic logic [RS_W:0] round_sat(input logic signed [RS_W-1:0] acc,
                                                input int shift, input int out_w,
                                                input bit out_signed);
        logic signed [RS_W-1:0] one, r, hi, lo;
        logic                   sat;
        one = RS_W'(1);
        if (shift > 0) r = (acc + (one <<< (shift - 1))) >>> shift;
        else           r = acc;
        if (out_signed) begin
            hi = (one <<< (out_w - 1)) - one;
            lo = -(one <<< (out_w - 1));
        end else begin
            hi = (one <<< out_w) - one;
            lo = '0;
        end
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return {r, sat};
    endfunction

endpackage

// File: rtl/pp_mac_pipe_multi_if.sv
// Stream bus for the MAC pipeline: input beat and output result channels.
interface pp_mac_if #(
    parameter int LANES = 3,
    parameter int A_W   = 12,
    parameter int B_W   = 9,
    parameter int OUT_W = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_mode;
    logic                         in_first;
    logic                         in_last;
    logic [LANES-1:0][A_W-1:0]    in_a;
    logic [LANES-1:0][B_W-1:0]    in_b;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0][OUT_W-1:0]  out_p;
    logic [LANES-1:0]             out_sat;

    modport slave (
        input  in_valid, in_mode, in_first, in_last, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, out_sat
    );

    modport master (
        output in_valid, in_mode, in_first, in_last, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, out_sat
    );
endinterface

// File: rtl/pp_mac_pipe_multi_lane.sv
// One lane of the MAC pipeline: operand regs, product, accumulator, round/sat.
// Control comes from the top; every stage advances on adv_i.
module pp_mac_lane
    import pp_mac_pkg::*;
#(
    parameter int A_W        = 12,
    parameter int A_SIGNED   = 0,
    parameter int B_W        = 9,
    parameter int ACC_GUARD  = 4,
    parameter int SHIFT      = 0,
    parameter int OUT_W      = 16,
    parameter int OUT_SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             acc_we_i,
    input  logic             acc_first_i,
    input  logic             mult_i,
    input  logic             out_we_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic [OUT_W-1:0] p_o,
    output logic             sat_o
);
    localparam int PROD_W = prod_w(A_W, B_W);
    localparam int ACC_W  = acc_w(A_W, B_W, ACC_GUARD);

    logic [A_W-1:0]             a_q;
    logic signed [B_W-1:0]      b_q;
    logic signed [A_W:0]        a_ext;
    logic signed [PROD_W-1:0]   prod_d, prod_q;
    logic signed [ACC_W-1:0]    prod_ext, acc_d, acc_q, accv_d, accv_q;
    logic [RS_W-1:0]            rs_val;
    logic                       rs_sat;
    logic [RS_W-OUT_W-1:0]      rs_unused;
    logic [OUT_W-1:0]           p_d, p_q;
    logic                       sat_d, sat_q;

    // Extra top bit lets an unsigned operand go through a signed multiplier.
    assign a_ext    = (A_SIGNED != 0) ? {a_q[A_W-1], a_q} : {1'b0, a_q};
    assign prod_d   = PROD_W'(a_ext) * PROD_W'(b_q);
    assign prod_ext = ACC_W'(prod_q);

    always_comb begin
        accv_d = accv_q;
        acc_d  = acc_q;
        if (mult_i)           accv_d = prod_ext;
        else if (acc_first_i) accv_d = prod_ext;
        else                  accv_d = acc_q + prod_ext;
        if (acc_we_i)         acc_d  = accv_d;
    end

    always_comb begin
        {rs_val, rs_sat} = round_sat(RS_W'(accv_q), SHIFT, OUT_W, OUT_SIGNED != 0);
        p_d   = p_q;
        sat_d = sat_q;
        if (out_we_i) begin
            p_d   = rs_val[OUT_W-1:0];
            sat_d = rs_sat;
        end
    end
    assign rs_unused = rs_val[RS_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            accv_q <= '0;
            p_q    <= '0;
            sat_q  <= 1'b0;
        end else if (adv_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            accv_q <= accv_d;
            p_q    <= p_d;
            sat_q  <= sat_d;
        end
    end

    assign p_o   = p_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/pp_mac_pipe_multi.sv
// LANES-wide 4-stage multiply / multiply-accumulate stream stage with a
// single global stall; control travels alongside the per-lane datapaths.
module pp_mac_pipe_multi
    import pp_mac_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int A_W        = 12,
    parameter int A_SIGNED   = 0,
    parameter int B_W        = 9,
    parameter int ACC_GUARD  = 4,
    parameter int SHIFT      = 0,
    parameter int OUT_W      = 16,
    parameter int OUT_SIGNED = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    pp_mac_if.slave  bus
);
    logic [3:1] vld_pipe_q;
    ctrl_t      c1_q, c2_q;
    mode_e      m3_q;
    logic       l3_q;
    logic       out_valid_q;
    logic       adv, emit3, acc_we2, mult2;

    assign adv     = bus.out_ready | ~out_valid_q;
    // MAC beats without last retire as bubbles at S4.
    assign emit3   = vld_pipe_q[3] & ((m3_q == MODE_MULT) | l3_q);
    assign acc_we2 = vld_pipe_q[2] & (c2_q.mode == MODE_MAC);
    assign mult2   = (c2_q.mode == MODE_MULT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            m3_q        <= MODE_MULT;
            l3_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            vld_pipe_q  <= {vld_pipe_q[2:1], bus.in_valid};
            c1_q        <= '{mode: mode_e'(bus.in_mode), first: bus.in_first, last: bus.in_last};
            c2_q        <= c1_q;
            m3_q        <= c2_q.mode;
            l3_q        <= c2_q.last;
            out_valid_q <= emit3;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pp_mac_lane #(
            .A_W(A_W), .A_SIGNED(A_SIGNED), .B_W(B_W), .ACC_GUARD(ACC_GUARD),
            .SHIFT(SHIFT), .OUT_W(OUT_W), .OUT_SIGNED(OUT_SIGNED)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .adv_i      (adv),
            .acc_we_i   (acc_we2),
            .acc_first_i(c2_q.first),
            .mult_i     (mult2),
            .out_we_i   (emit3),
            .a_i        (bus.in_a[l]),
            .b_i        (bus.in_b[l]),
            .p_o        (bus.out_p[l]),
            .sat_o      (bus.out_sat[l])
        );
    end

endmodule

// File: tb/tb_pp_mac_pipe_multi.sv
// Directed bench: wide-output DUT (OUT_W=21, SHIFT=0) for MULT/MAC/stall/reset,
// narrow DUT (OUT_W=8, SHIFT=2) for saturation and rounding.
module tb_pp_mac_pipe_multi;
    typedef logic [2:0][11:0] av_t;
    typedef logic [2:0][8:0]  bv_t;
    typedef logic [2:0][20:0] pv_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    pv_t         q_p[$];
    logic [2:0]  q_s[$];

    always #5 clk = ~clk;

    pp_mac_if #(.LANES(3), .A_W(12), .B_W(9), .OUT_W(21)) bus ();
    pp_mac_if #(.LANES(3), .A_W(12), .B_W(9), .OUT_W(8))  xbus ();

    pp_mac_pipe_multi #(.LANES(3), .A_W(12), .A_SIGNED(0), .B_W(9), .ACC_GUARD(4),
                        .SHIFT(0), .OUT_W(21), .OUT_SIGNED(1))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    pp_mac_pipe_multi #(.LANES(3), .A_W(12), .A_SIGNED(0), .B_W(9), .ACC_GUARD(4),
                        .SHIFT(2), .OUT_W(8), .OUT_SIGNED(1))
        dut_x (.clk(clk), .rst_n(rst_n), .bus(xbus));

    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            q_p.push_back(bus.out_p);
            q_s.push_back(bus.out_sat);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_a = '0; bus.in_b = '0;
        xbus.in_valid = 1'b0; xbus.in_mode = 1'b0; xbus.in_first = 1'b0; xbus.in_last = 1'b0;
        xbus.in_a = '0; xbus.in_b = '0; xbus.out_ready = 1'b1;
    endtask

    // Presents a beat and returns one cycle after it has been accepted.
    task automatic send(input logic mode, input logic first, input logic last,
                        input av_t a, input bv_t b);
        logic acc;
        bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_first = first; bus.in_last = last;
        bus.in_a = a; bus.in_b = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_chk++; n_fail++;
        $display("FAIL send_timeout: beat not accepted within 50 cycles");
    endtask

    task automatic clear_q();
        q_p.delete();
        q_s.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        set_idle();
        repeat (3) tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        n_chk++; if (bus.out_p !== '0) begin n_fail++; $display("FAIL reset_out_p: got %h, expected 0", bus.out_p); end
        n_chk++; if (bus.out_sat !== 3'b000) begin n_fail++; $display("FAIL reset_out_sat: got %b, expected 000", bus.out_sat); end
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        pv_t exp;
        exp = {21'(522240), 21'(-1), 21'(-1048320)};
        send(1'b0, 1'b0, 1'b0, {12'd2048, 12'd1, 12'd4095}, {9'(255), 9'(-1), 9'(-256)});
        set_idle();
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mult_early_valid: cycle %0d got %b, expected 0", k + 1, bus.out_valid); end
            tick();
        end
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mult_latency: got out_valid %b, expected 1", bus.out_valid); end
        n_chk++; if (bus.out_p !== exp) begin n_fail++; $display("FAIL mult_out_p: got %h, expected %h", bus.out_p, exp); end
        n_chk++; if (bus.out_sat !== 3'b000) begin n_fail++; $display("FAIL mult_out_sat: got %b, expected 000", bus.out_sat); end
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mult_single: got out_valid %b, expected 0", bus.out_valid); end
    endtask

    task automatic test_mac();
        pv_t exp;
        exp = {21'(0), 21'(-1048576), 21'(2000)};
        clear_q();
        send(1'b1, 1'b1, 1'b0, {12'd0, 12'd4095, 12'd100}, {9'(77), 9'(-256), 9'(2)});
        send(1'b1, 1'b0, 1'b0, {12'd0, 12'd4095, 12'd200}, {9'(77), 9'(-256), 9'(3)});
        send(1'b1, 1'b0, 1'b1, {12'd0, 12'd4095, 12'd300}, {9'(77), 9'(-256), 9'(4)});
        set_idle();
        repeat (8) tick();
        n_chk++; if (q_p.size() !== 1) begin n_fail++; $display("FAIL mac_count: got %0d results, expected 1", q_p.size()); end
        if (q_p.size() > 0) begin
            n_chk++; if (q_p[0] !== exp) begin n_fail++; $display("FAIL mac_sum: got %h, expected %h", q_p[0], exp); end
            n_chk++; if (q_s[0] !== 3'b010) begin n_fail++; $display("FAIL mac_sat: got %b, expected 010", q_s[0]); end
        end
    endtask

    task automatic test_mac_interleave();
        int exp[3] = '{21, 20, -9};
        clear_q();
        send(1'b1, 1'b1, 1'b0, {12'd0, 12'd0, 12'd10}, {9'(0), 9'(0), 9'(1)});
        send(1'b0, 1'b0, 1'b0, {12'd0, 12'd0, 12'd7},  {9'(0), 9'(0), 9'(3)});
        send(1'b1, 1'b0, 1'b1, {12'd0, 12'd0, 12'd5},  {9'(0), 9'(0), 9'(2)});
        send(1'b1, 1'b1, 1'b1, {12'd0, 12'd0, 12'd3},  {9'(0), 9'(0), 9'(-3)});
        set_idle();
        repeat (8) tick();
        n_chk++; if (q_p.size() !== 3) begin n_fail++; $display("FAIL interleave_count: got %0d results, expected 3", q_p.size()); end
        for (int k = 0; k < 3 && k < q_p.size(); k++) begin
            n_chk++;
            if (q_p[k][0] !== 21'(exp[k])) begin
                n_fail++; $display("FAIL interleave_val[%0d]: got %0d, expected %0d", k, $signed(q_p[k][0]), exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        pv_t hold;
        pv_t exp;
        int  stall_cyc;
        clear_q();
        stall_cyc = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(1'b0, 1'b0, 1'b0, {12'(4095 - i), 12'(i * 100), 12'(i + 1)},
                         {9'(-1), 9'(7), 9'(i - 4)});
                set_idle();
            end
            begin
                repeat (5) tick();
                bus.out_ready = 1'b0;
                hold = bus.out_p;
                for (int k = 0; k < 6; k++) begin
                    tick();
                    if (bus.in_ready === 1'b0) stall_cyc++;
                end
                n_chk++; if (bus.out_valid !== 1'b1 || bus.out_p !== hold) begin
                    n_fail++; $display("FAIL stall_hold: got valid %b p %h, expected valid 1 p %h", bus.out_valid, bus.out_p, hold);
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (12) tick();
        n_chk++; if (stall_cyc != 6) begin n_fail++; $display("FAIL in_ready_drop: got %0d stalled cycles, expected 6", stall_cyc); end
        n_chk++; if (q_p.size() !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d results, expected 10", q_p.size()); end
        for (int i = 0; i < 10 && i < q_p.size(); i++) begin
            exp = {21'(-(4095 - i)), 21'(700 * i), 21'((i + 1) * (i - 4))};
            n_chk++;
            if (q_p[i] !== exp) begin
                n_fail++; $display("FAIL b2b_order[%0d]: got %h, expected %h", i, q_p[i], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        send(1'b1, 1'b1, 1'b0, {12'd0, 12'd0, 12'd1000}, {9'(0), 9'(0), 9'(100)});
        send(1'b1, 1'b0, 1'b0, {12'd0, 12'd0, 12'd1000}, {9'(0), 9'(0), 9'(100)});
        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", bus.out_valid); end
        n_chk++; if (bus.out_p !== '0) begin n_fail++; $display("FAIL rstmid_out_p: got %h, expected 0", bus.out_p); end
        repeat (3) tick();
        send(1'b1, 1'b1, 1'b0, {12'd0, 12'd0, 12'd7}, {9'(0), 9'(0), 9'(2)});
        send(1'b1, 1'b0, 1'b1, {12'd0, 12'd0, 12'd1}, {9'(0), 9'(0), 9'(3)});
        set_idle();
        repeat (8) tick();
        n_chk++; if (q_p.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d results, expected 1", q_p.size()); end
        if (q_p.size() > 0) begin
            n_chk++; if (q_p[0][0] !== 21'(17)) begin n_fail++; $display("FAIL rstmid_sum: got %0d, expected 17", $signed(q_p[0][0])); end
        end
    endtask

    // Single MULT beat on the narrow (OUT_W=8, SHIFT=2) instance, lane 0.
    task automatic x_mult(input int a, input int b, input int exp_p, input logic exp_sat,
                          input string name);
        bit seen;
        xbus.in_valid = 1'b1; xbus.in_mode = 1'b0;
        xbus.in_a = {12'd0, 12'd0, 12'(a)};
        xbus.in_b = {9'(0), 9'(0), 9'(b)};
        tick();
        set_idle();
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (xbus.out_valid === 1'b1) seen = 1'b1;
            else tick();
        end
        n_chk++;
        if (!seen) begin
            n_fail++; $display("FAIL %s: no result within 10 cycles, expected %0d", name, exp_p);
        end else if (xbus.out_p[0] !== 8'(exp_p) || xbus.out_sat[0] !== exp_sat) begin
            n_fail++; $display("FAIL %s: got %0d sat %b, expected %0d sat %b",
                               name, $signed(xbus.out_p[0]), xbus.out_sat[0], exp_p, exp_sat);
        end
        tick();
    endtask

    task automatic test_saturation();
        x_mult(100, 100, 127, 1'b1, "sat_pos");
        x_mult(100, -100, -128, 1'b1, "sat_neg");
        x_mult(254, 2, 127, 1'b0, "sat_edge_max");
        x_mult(256, 2, 127, 1'b1, "sat_edge_over");
        x_mult(40, 12, 120, 1'b0, "sat_none");
    endtask

    task automatic test_rounding();
        x_mult(5, 1, 1, 1'b0, "round_5");
        x_mult(6, 1, 2, 1'b0, "round_6");
        x_mult(6, -1, -1, 1'b0, "round_neg6");
        x_mult(7, -1, -2, 1'b0, "round_neg7");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mac();
        test_mac_interleave();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_rounding();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
